// File: rtl/sub_64_bit_pipe_if.sv
// Operand/result bus for the pipelined subtractor: valid/ready on both sides.
interface sub_64_bit_pipe_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, x, y, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  in_valid, x, y, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow, zero
  );
endinterface

// File: rtl/sub_64_bit_pipe.sv
// Two-stage x - y - borrow_in: low half in stage 1, high half in stage 2 off the
// registered low-half carry. Full valid/ready flow control, one op per cycle.
module sub_64_bit_pipe #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  sub_64_bit_pipe_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_dlo_q, s1_dlo_d;
  logic            s1_c1_q, s1_c1_d;
  logic [HALF-1:0] s1_xhi_q, s1_xhi_d;
  logic [HALF-1:0] s1_yhi_q, s1_yhi_d;
  logic            s1_zlo_q, s1_zlo_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic            s2_ready, accept, advance;
  logic [HALF:0]   lo_sum, hi_sum;

  assign s2_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign advance  = s1_valid_q && s2_ready;

  // Subtraction as x + ~y + carry, with carry = !borrow.
  assign lo_sum = {1'b0, bus.x[HALF-1:0]} + {1'b0, ~bus.y[HALF-1:0]}
                + {{HALF{1'b0}}, ~bus.borrow_in};
  assign hi_sum = {1'b0, s1_xhi_q} + {1'b0, ~s1_yhi_q} + {{HALF{1'b0}}, s1_c1_q};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_dlo_d    = s1_dlo_q;
    s1_c1_d     = s1_c1_q;
    s1_xhi_d    = s1_xhi_q;
    s1_yhi_d    = s1_yhi_q;
    s1_zlo_d    = s1_zlo_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_dlo_d   = lo_sum[HALF-1:0];
      s1_c1_d    = lo_sum[HALF];
      s1_xhi_d   = bus.x[WIDTH-1:HALF];
      s1_yhi_d   = bus.y[WIDTH-1:HALF];
      s1_zlo_d   = (lo_sum[HALF-1:0] == '0);
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    // Output regs only change on advance, so they hold under backpressure.
    if (advance) begin
      out_valid_d = 1'b1;
      diff_d      = {hi_sum[HALF-1:0], s1_dlo_q};
      borrow_d    = !hi_sum[HALF];
      ovf_d       = (s1_xhi_q[HALF-1] != s1_yhi_q[HALF-1]) &&
                    (hi_sum[HALF-1] != s1_xhi_q[HALF-1]);
      zero_d      = s1_zlo_q && (hi_sum[HALF-1:0] == '0);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_dlo_q    <= '0;
      s1_c1_q     <= 1'b0;
      s1_xhi_q    <= '0;
      s1_yhi_q    <= '0;
      s1_zlo_q    <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dlo_q    <= s1_dlo_d;
      s1_c1_q     <= s1_c1_d;
      s1_xhi_q    <= s1_xhi_d;
      s1_yhi_q    <= s1_yhi_d;
      s1_zlo_q    <= s1_zlo_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready   = !s1_valid_q || s2_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;
endmodule

// File: tb/tb_sub_64_bit_pipe.sv
// Randomized and directed bench for sub_64_bit_pipe against a wide-arithmetic model.
module tb_sub_64_bit_pipe;
  typedef struct packed {
    logic [63:0] d;
    logic        b;
    logic        o;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub_64_bit_pipe_if #(.WIDTH(64)) ifc();
  sub_64_bit_pipe #(.WIDTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  res_t exp_q[$];
  res_t obs_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference: exact integer subtraction in wider precision.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
    logic [64:0]        full;
    logic signed [65:0] s;
    res_t               r;
    full = {1'b0, a} - {1'b0, b} - 65'(bi);
    s    = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed(66'(bi));
    r.d  = full[63:0];
    r.b  = full[64];
    r.o  = (s > $signed(66'h0_7FFF_FFFF_FFFF_FFFF)) ||
           (s < -$signed(66'h0_8000_0000_0000_0000));
    r.z  = (r.d == 64'd0);
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.d = ifc.diff; r.b = ifc.borrow_out; r.o = ifc.overflow; r.z = ifc.zero;
    return r;
  endfunction

  // Called at a negedge with inputs already driven; samples handshakes, then steps one cycle.
  task automatic tick(output bit acc, output bit fire);
    #1;
    acc  = ifc.in_valid && ifc.in_ready;
    fire = ifc.out_valid && ifc.out_ready;
    if (acc)  exp_q.push_back(model(ifc.x, ifc.y, ifc.borrow_in));
    if (fire) obs_q.push_back(observed());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ifc.in_valid = 1'b0; ifc.x = '0; ifc.y = '0; ifc.borrow_in = 1'b0; ifc.out_ready = 1'b1;
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({ifc.out_valid, ifc.diff, ifc.borrow_out, ifc.overflow, ifc.zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h b=%b o=%b z=%b want all zero",
               ifc.out_valid, ifc.diff, ifc.borrow_out, ifc.overflow, ifc.zero);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (ifc.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] tx [7] = '{64'd5, 64'd0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000,
                            64'h8000_0000_0000_0000, 64'd0, 64'hDEAD_BEEF_CAFE_F00D};
    logic [63:0] ty [7] = '{64'd3, 64'd1, 64'h1234_5678_9ABC_DEF0, 64'd1,
                            64'd1, 64'd0, 64'hDEAD_BEEF_CAFE_F00D};
    logic        tbi[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    res_t        tw [7] = '{{64'd2, 1'b0, 1'b0, 1'b0},
                            {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0},
                            {64'd0, 1'b0, 1'b0, 1'b1},
                            {64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0},
                            {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0},
                            {64'd0, 1'b0, 1'b0, 1'b1},
                            {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    bit a, f;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ifc.x = tx[i]; ifc.y = ty[i]; ifc.borrow_in = tbi[i]; ifc.in_valid = 1'b1;
      tick(a, f);
      ifc.in_valid = 1'b0;
      n_tests++;
      if (ifc.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir_early_valid[%0d]: got %b want 0", i, ifc.out_valid);
      end
      tick(a, f);
      n_tests++;
      if (ifc.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL dir_latency[%0d]: got out_valid %b want 1", i, ifc.out_valid);
      end
      n_tests++;
      if (observed() !== tw[i]) begin
        n_fail++; $display("FAIL dir_result[%0d]: got %h want %h", i, observed(), tw[i]);
      end
      tick(a, f);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit a, f;
    int fire_cyc[$];
    int cyc = 0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifc.x = {$urandom, $urandom};
      ifc.y = (i == 2) ? ifc.x : {$urandom, $urandom};
      ifc.borrow_in = (i % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ifc.in_valid = 1'b1;
      tick(a, f);
      if (f) fire_cyc.push_back(cyc);
      cyc++;
      n_tests++;
      if (!a) begin n_fail++; $display("FAIL b2b_accept[%0d]: got 0 want 1", i); end
    end
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(a, f);
      if (f) fire_cyc.push_back(cyc);
      cyc++;
    end
    n_tests++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 8", obs_q.size());
    end
    for (int k = 0; k < fire_cyc.size(); k++) begin
      n_tests++;
      if (fire_cyc[k] != 2 + k) begin
        n_fail++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", k, fire_cyc[k], 2 + k);
      end
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    bit   a, f, stall, saw_low;
    res_t snap;
    int   issued = 0;
    int   fire_cyc[$];
    logic [63:0] px, py;
    logic        pb;
    px = {$urandom, $urandom}; py = {$urandom, $urandom}; pb = 1'($urandom_range(0, 1));
    saw_low = 1'b0;
    for (int cyc = 0; cyc < 60 && obs_q.size() < 10; cyc++) begin
      ifc.out_ready = !(cyc >= 2 && cyc < 7);
      ifc.in_valid  = (issued < 10);
      ifc.x = px; ifc.y = py; ifc.borrow_in = pb;
      #1;
      stall = ifc.out_valid && !ifc.out_ready;
      snap  = observed();
      if (stall && !ifc.in_ready) saw_low = 1'b1;
      tick(a, f);
      if (f) fire_cyc.push_back(cyc);
      if (a) begin
        issued++;
        px = {$urandom, $urandom}; py = {$urandom, $urandom}; pb = 1'($urandom_range(0, 1));
      end
      if (stall) begin
        n_tests++;
        if (ifc.out_valid !== 1'b1 || observed() !== snap) begin
          n_fail++; $display("FAIL bp_stable[%0d]: got v=%b %h want v=1 %h",
                             cyc, ifc.out_valid, observed(), snap);
        end
      end
    end
    ifc.in_valid = 1'b0;
    n_tests++;
    if (!saw_low) begin n_fail++; $display("FAIL bp_in_ready_low: got never-low want low"); end
    n_tests++;
    if (obs_q.size() != 10 || exp_q.size() != 10) begin
      n_fail++; $display("FAIL bp_count: got %0d/%0d want 10", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < fire_cyc.size(); k++) begin
      n_tests++;
      if (fire_cyc[k] != 7 + k) begin
        n_fail++; $display("FAIL bp_resume[%0d]: got cycle %0d want %0d", k, fire_cyc[k], 7 + k);
      end
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL bp_result[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); obs_q.delete();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(a, f);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    bit a, f;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifc.x = {$urandom, $urandom}; ifc.y = {$urandom, $urandom}; ifc.borrow_in = 1'b0;
      ifc.in_valid = 1'b1;
      tick(a, f);
    end
    ifc.in_valid = 1'b0;
    #1;
    n_tests++;
    if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", ifc.out_valid, ifc.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.diff !== 64'd0) begin
      n_fail++; $display("FAIL mid_async_reset: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0",
                         ifc.out_valid, ifc.in_ready, ifc.diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(a, f);
      n_tests++;
      if (ifc.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale[%0d]: got out_valid %b want 0", i, ifc.out_valid);
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL mid_no_result: got %0d results want 0", obs_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
